// File: rtl/md_unit_pkg.sv
// md_unit_pkg: HILO op codes shared by the decoder and the multiply/divide unit
package md_unit_pkg;
    typedef enum logic [3:0] {
        HILO_NONE  = 4'd0,
        HILO_MULT  = 4'd1,
        HILO_MULTU = 4'd2,
        HILO_DIV   = 4'd3,
        HILO_DIVU  = 4'd4,
        HILO_MFHI  = 4'd5,
        HILO_MFLO  = 4'd6,
        HILO_MTHI  = 4'd7,
        HILO_MTLO  = 4'd8
    } hilo_t;

    function automatic logic is_md(hilo_t op);
        return op == HILO_MULT || op == HILO_MULTU || op == HILO_DIV || op == HILO_DIVU;
    endfunction

    function automatic logic is_div(hilo_t op);
        return op == HILO_DIV || op == HILO_DIVU;
    endfunction
endpackage

// File: rtl/md_arith.sv
// md_arith: combinational mult/div datapath producing {hi,lo} and a divide-by-zero flag
module md_arith
    import md_unit_pkg::*;
(
    input  hilo_t       op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] res,
    output logic        div_zero
);
    logic [31:0] ubs, sbs, uq, ur;
    logic signed [31:0] sq, sr;
    logic [63:0] sp, up;
    // Divisor replaced by 1 for /0 and for the signed overflow case, which then yields {0, a}
    assign ubs = (b == '0) ? 32'd1 : b;
    assign sbs = (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd1 : ubs;
    assign sq = $signed(a) / $signed(sbs);
    assign sr = $signed(a) % $signed(sbs);
    assign uq = a / ubs;
    assign ur = a % ubs;
    assign sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign up = {32'b0, a} * {32'b0, b};
    assign res = op == HILO_MULT  ? sp :
                 op == HILO_MULTU ? up :
                 op == HILO_DIV   ? {sr, sq} : {ur, uq};
    assign div_zero = is_div(op) && b == '0;
endmodule

// File: rtl/md_unit.sv
// md_unit: execute-stage multi-cycle multiply/divide unit owning HI/LO
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  hilo_type,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        start,
    output logic        busy,
    output logic [31:0] hilo_out
);
    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    hilo_t          op, op_q;
    logic [31:0]    a_q, b_q, hi, lo;
    logic [CW-1:0]  cnt;
    logic [63:0]    res;
    logic           dz;

    assign op       = hilo_t'(hilo_type);
    assign start    = is_md(op) && !busy;
    assign hilo_out = op == HILO_MFHI ? hi : lo;

    md_arith u_arith (
        .op       (op_q),
        .a        (a_q),
        .b        (b_q),
        .res      (res),
        .div_zero (dz)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q <= HILO_NONE;
            a_q  <= '0;
            b_q  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            hi   <= '0;
            lo   <= '0;
        end else begin
            if (start) begin
                op_q <= op;
                a_q  <= rs_val;
                b_q  <= rt_val;
                cnt  <= is_div(op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                busy <= 1'b1;
            end else if (busy) begin
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    if (!dz) begin
                        hi <= res[63:32];
                        lo <= res[31:0];
                    end
                end
            end
            if (!busy && op == HILO_MTHI) hi <= rs_val;
            if (!busy && op == HILO_MTLO) lo <= rs_val;
        end
    end
endmodule
